// File: rtl/prog_clk_div_ctrl.sv
// Programmable divide-by-N control: one-cycle enable strobe plus divided square wave.
// The divisor is loaded by valid/ready; changes made while running land on a period boundary.
module prog_clk_div_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             run,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             tick,
  output logic             div_out,
  output logic             active
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             tick_q, tick_d;
  logic             div_out_q, div_out_d;

  logic             accept_nz;
  logic             last_cnt;
  logic [WIDTH:0]   half_d;

  // Zero divisors complete the handshake but are dropped.
  assign div_ready = rst & ((state_q == StIdle) | ~pend_valid_q);
  assign accept_nz = div_valid & div_ready & (div_in != '0);
  assign last_cnt  = (cnt_q == (div_q - One));
  assign half_d    = ({1'b0, div_d} + (WIDTH + 1)'(1)) >> 1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    tick_d       = 1'b0;
    div_out_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Start decision uses the divisor held before this edge.
        if (run && (div_q != '0)) begin
          state_d = StRun;
          cnt_d   = '0;
        end
        if (accept_nz) begin
          div_d = div_in;
        end
      end
      StRun: begin
        if (!run) begin
          state_d      = StIdle;
          cnt_d        = '0;
          pend_valid_d = 1'b0;
          // Nothing may stay pending in IDLE, so anything in flight lands in div_reg.
          if (accept_nz) begin
            div_d = div_in;
          end else if (pend_valid_q) begin
            div_d = pend_q;
          end
        end else begin
          if (last_cnt) begin
            cnt_d = '0;
            if (pend_valid_q) begin
              div_d        = pend_q;
              pend_valid_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + One;
          end
          // Only possible with pend_valid_q low, so never collides with the swap above.
          if (accept_nz) begin
            pend_d       = div_in;
            pend_valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Registered outputs are decoded from the next-state counter and divisor.
    if (state_d == StRun) begin
      tick_d    = (cnt_d == (div_d - One));
      div_out_d = ({1'b0, cnt_d} < half_d);
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      div_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      tick_q       <= 1'b0;
      div_out_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      tick_q       <= tick_d;
      div_out_q    <= div_out_d;
    end
  end

  assign tick    = tick_q;
  assign div_out = div_out_q;
  assign active  = (state_q == StRun);

endmodule

// File: tb/tb_prog_clk_div_ctrl.sv
// Bench for prog_clk_div_ctrl: directed steps plus random traffic against a period-level model.
module tb_prog_clk_div_ctrl;

  logic       clock;
  logic       rst;
  logic       run;
  logic [7:0] div_in;
  logic       div_valid;
  logic       div_ready;
  logic       tick;
  logic       div_out;
  logic       active;

  int checks = 0;
  int errors = 0;

  // Model: running flag, position within current period, current/pending divisor.
  bit m_running;
  int m_ph;
  int m_div;
  int m_pend;
  bit m_pv;

  prog_clk_div_ctrl #(.WIDTH(8)) dut (
    .clock    (clock),
    .rst      (rst),
    .run      (run),
    .div_in   (div_in),
    .div_valid(div_valid),
    .div_ready(div_ready),
    .tick     (tick),
    .div_out  (div_out),
    .active   (active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_running = 0;
    m_ph      = 0;
    m_div     = 0;
    m_pend    = 0;
    m_pv      = 0;
  endtask

  function automatic bit exp_ready();
    return rst && (!m_running || !m_pv);
  endfunction

  task automatic model_step(input bit r, input bit v, input int d);
    bit acc;
    acc = v && exp_ready() && (d != 0);
    if (!m_running) begin
      if (r && m_div != 0) begin
        m_running = 1;
        m_ph      = 0;
      end
      if (acc) m_div = d;
    end else if (!r) begin
      m_running = 0;
      m_ph      = 0;
      if (acc) m_div = d;
      else if (m_pv) m_div = m_pend;
      m_pv = 0;
    end else begin
      if (m_ph == m_div - 1) begin
        m_ph = 0;
        if (m_pv) begin
          m_div = m_pend;
          m_pv  = 0;
        end
      end else begin
        m_ph++;
      end
      if (acc) begin
        m_pend = d;
        m_pv   = 1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    bit e_tick, e_dout;
    e_tick = m_running && (m_ph == m_div - 1);
    e_dout = m_running && (m_ph < (m_div + 1) / 2);
    check({tag, ".tick"}, {31'd0, tick}, {31'd0, e_tick});
    check({tag, ".div_out"}, {31'd0, div_out}, {31'd0, e_dout});
    check({tag, ".active"}, {31'd0, active}, {31'd0, m_running});
  endtask

  // Inputs change 1 time unit after a rising edge; outputs sampled 1 unit after the next one.
  task automatic cycle(input string tag, input bit r, input bit v, input int d);
    run       = r;
    div_valid = v;
    div_in    = d[7:0];
    #1;
    check({tag, ".div_ready"}, {31'd0, div_ready}, {31'd0, exp_ready()});
    @(posedge clock);
    if (rst) model_step(r, v, d);
    #1;
    check_outputs(tag);
  endtask

  task automatic stop_and_load(input string tag, input int d);
    cycle(tag, 0, 0, 0);
    cycle(tag, 0, 1, d);
  endtask

  initial begin
    int ticks;
    rst       = 1'b0;
    run       = 1'b0;
    div_valid = 1'b0;
    div_in    = '0;
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    check("reset.div_ready", {31'd0, div_ready}, 32'd0);
    check_outputs("reset");
    rst = 1'b1;

    // N=4: pattern 1100, tick at phase 3; count ticks over 12 run cycles.
    cycle("n4_load", 0, 1, 4);
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      cycle("n4_run", 1, 0, 0);
      if (tick === 1'b1) ticks++;
    end
    check("n4_tick_count", ticks, 3);

    // N=5: pattern 11100.
    stop_and_load("n5_load", 5);
    for (int i = 0; i < 15; i++) cycle("n5_run", 1, 0, 0);

    // N=6 with a mid-period change to 3; valid held while not ready.
    stop_and_load("n6_load", 6);
    for (int i = 0; i < 40 && !(m_running && m_ph == 2); i++) cycle("n6_run", 1, 0, 0);
    check("n6_reached_cnt2", m_ph, 2);
    cycle("n6_offer3", 1, 1, 3);
    cycle("n6_hold", 1, 1, 7);
    cycle("n6_hold", 1, 1, 7);
    for (int i = 0; i < 12; i++) cycle("n3_run", 1, 0, 0);

    // Zero divisor in RUN and in IDLE is ignored.
    cycle("zero_run", 1, 1, 0);
    for (int i = 0; i < 6; i++) cycle("zero_run_after", 1, 0, 0);
    cycle("zero_idle", 0, 1, 0);
    for (int i = 0; i < 6; i++) cycle("zero_idle_run", 1, 0, 0);

    // N=1: both outputs constantly high, then stop.
    stop_and_load("n1_load", 1);
    for (int i = 0; i < 5; i++) cycle("n1_run", 1, 0, 0);
    cycle("n1_stop", 0, 0, 0);

    // N=8 with a pending divisor, then asynchronous reset mid-period.
    cycle("n8_load", 0, 1, 8);
    for (int i = 0; i < 40 && !(m_running && m_ph == 1); i++) cycle("n8_run", 1, 0, 0);
    cycle("n8_pend", 1, 1, 5);
    check("n8_div_out_high", {31'd0, div_out}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("async.tick", {31'd0, tick}, 32'd0);
    check("async.div_out", {31'd0, div_out}, 32'd0);
    check("async.active", {31'd0, active}, 32'd0);
    check("async.div_ready", {31'd0, div_ready}, 32'd0);
    @(posedge clock);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) cycle("post_rst_run", 1, 0, 0);
    cycle("post_rst_load", 1, 1, 4);
    for (int i = 0; i < 8; i++) cycle("post_rst_n4", 1, 0, 0);

    // Random traffic, mostly small divisors with an occasional large one.
    for (int i = 0; i < 600; i++) begin
      bit r, v;
      int d;
      r = ($urandom_range(0, 24) != 0);
      v = ($urandom_range(0, 5) == 0);
      d = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9);
      cycle("rand", r, v, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
